sd_sector_responder: RTL and testbench

//  RAM-backed responder on the SD-card side of the sector read/write handshake.

---
 rtl/sd_sector_responder.sv | 211 +++++++++++++++++++++
 tb/tb_sd_sector_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_responder.sv
// RAM-backed stand-in for an SD controller on the sector read/write handshake.
// Accepts whole-sector write/read requests, pulls write words with wr_req,
// returns read words with rd_data_en, and reports init/busy status.
module sd_sector_responder #(
  parameter int unsigned WORD_NUM    = 256,
  parameter int unsigned SECTOR_NUM  = 4,
  parameter int unsigned INIT_CYCLES = 100,
  parameter int unsigned CMD_LAT     = 8,
  parameter int unsigned WORD_GAP    = 4,
  parameter int unsigned PROG_LAT    = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic        init_end,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  output logic        wr_req,
  input  logic [15:0] wr_data,
  output logic        wr_busy,
  input  logic        rd_en,
  input  logic [31:0] rd_addr,
  output logic        rd_data_en,
  output logic [15:0] rd_data,
  output logic        rd_busy
);

  localparam int unsigned SlotW = (SECTOR_NUM > 1) ? $clog2(SECTOR_NUM) : 1;
  localparam int unsigned PtrW  = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;
  localparam int unsigned NumW  = $clog2(WORD_NUM + 1);
  localparam int unsigned CntW  = 16;
  localparam int unsigned Depth = 1 << (SlotW + PtrW);

  typedef enum logic [2:0] {
    StInit, StIdle, StWCmd, StWData, StWProg, StRCmd, StRData
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [NumW-1:0]  wcnt_q, wcnt_d;   // write pulses issued
  logic [NumW-1:0]  rcnt_q, rcnt_d;   // read strobes issued
  logic [PtrW-1:0]  wptr_q, wptr_d;   // next word index to capture
  logic [PtrW-1:0]  rptr_q, rptr_d;   // next word index to present
  logic [SlotW-1:0] slot_q, slot_d;
  logic             init_end_q, init_end_d;
  logic             wr_req_q, wr_req_d;
  logic             cap_q, cap_d;     // wr_data is valid this cycle
  logic             wr_busy_q, wr_busy_d;
  logic             rd_busy_q, rd_busy_d;
  logic             rd_data_en_q, rd_data_en_d;
  logic [15:0]      rd_data_q, rd_data_d;
  logic [15:0]      ram_q;

  logic [15:0]             mem [Depth];
  logic [SlotW+PtrW-1:0]   waddr, raddr;

  // Only the slot index bits of the sector address matter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr[31:SlotW], rd_addr[31:SlotW]};

  assign waddr = {slot_q, wptr_q};
  // Read address follows next-state pointer so ram_q already holds the word to present.
  assign raddr = {slot_d, rptr_d};

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:  if (cnt_q == CntW'(INIT_CYCLES - 1)) state_d = StIdle;
      StIdle: begin
        if (wr_en) begin
          state_d = StWCmd;
        end else if (rd_en) begin
          state_d = StRCmd;
        end
      end
      StWCmd:  if (cnt_q == CntW'(CMD_LAT - 1)) state_d = StWData;
      // Leave once the final pulse is visible; its capture lands in the first prog cycle.
      StWData: if (wr_req_q && (wcnt_q == NumW'(WORD_NUM))) state_d = StWProg;
      StWProg: if (cnt_q == CntW'(PROG_LAT - 1)) state_d = StIdle;
      // One extra cycle over CMD_LAT covers the RAM prefetch.
      StRCmd:  if (cnt_q == CntW'(CMD_LAT)) state_d = StRData;
      StRData: if (rd_data_en_q && (rcnt_q == NumW'(WORD_NUM))) state_d = StIdle;
      default: state_d = StInit;
    endcase
  end

  // Output and counter next-state.
  always_comb begin
    cnt_d        = (state_d != state_q) ? '0 : cnt_q + CntW'(1);
    wcnt_d       = wcnt_q;
    rcnt_d       = rcnt_q;
    wptr_d       = cap_q ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d       = rptr_q;
    slot_d       = slot_q;
    init_end_d   = init_end_q;
    wr_busy_d    = wr_busy_q;
    rd_busy_d    = rd_busy_q;
    wr_req_d     = 1'b0;
    cap_d        = wr_req_q;
    rd_data_en_d = 1'b0;
    rd_data_d    = rd_data_q;
    unique case (state_q)
      StInit: if (state_d == StIdle) init_end_d = 1'b1;
      StIdle: begin
        if (state_d == StWCmd) begin
          slot_d    = wr_addr[SlotW-1:0];
          wr_busy_d = 1'b1;
          wcnt_d    = '0;
          wptr_d    = '0;
        end else if (state_d == StRCmd) begin
          slot_d    = rd_addr[SlotW-1:0];
          rd_busy_d = 1'b1;
          rcnt_d    = '0;
          rptr_d    = '0;
        end
      end
      StWCmd: begin
        if (state_d == StWData) begin
          wr_req_d = 1'b1;
          wcnt_d   = NumW'(1);
        end
      end
      StWData: begin
        if ((state_d == StWData) && (cnt_q == CntW'(WORD_GAP - 1)) &&
            (wcnt_q < NumW'(WORD_NUM))) begin
          wr_req_d = 1'b1;
          wcnt_d   = wcnt_q + NumW'(1);
          cnt_d    = '0;
        end
      end
      StWProg: if (state_d == StIdle) wr_busy_d = 1'b0;
      StRCmd: begin
        if (state_d == StRData) begin
          rd_data_en_d = 1'b1;
          rd_data_d    = ram_q;
          rptr_d       = rptr_q + PtrW'(1);
          rcnt_d       = NumW'(1);
        end
      end
      StRData: begin
        if (state_d == StIdle) begin
          rd_busy_d = 1'b0;
        end else if ((cnt_q == CntW'(WORD_GAP - 1)) && (rcnt_q < NumW'(WORD_NUM))) begin
          rd_data_en_d = 1'b1;
          rd_data_d    = ram_q;
          rptr_d       = rptr_q + PtrW'(1);
          rcnt_d       = rcnt_q + NumW'(1);
          cnt_d        = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q        <= '0;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      slot_q       <= '0;
      init_end_q   <= 1'b0;
      wr_req_q     <= 1'b0;
      cap_q        <= 1'b0;
      wr_busy_q    <= 1'b0;
      rd_busy_q    <= 1'b0;
      rd_data_en_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      cnt_q        <= cnt_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      slot_q       <= slot_d;
      init_end_q   <= init_end_d;
      wr_req_q     <= wr_req_d;
      cap_q        <= cap_d;
      wr_busy_q    <= wr_busy_d;
      rd_busy_q    <= rd_busy_d;
      rd_data_en_q <= rd_data_en_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Sector storage: no reset, so contents survive a reset; a pending capture is dropped.
  always_ff @(posedge sys_clk) begin
    if (cap_q && !sys_rst) mem[waddr] <= wr_data;
    ram_q <= mem[raddr];
  end

  assign init_end   = init_end_q;
  assign wr_req     = wr_req_q;
  assign wr_busy    = wr_busy_q;
  assign rd_busy    = rd_busy_q;
  assign rd_data_en = rd_data_en_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_sd_sector_responder.sv
// Directed-plus-random bench for sd_sector_responder. Timing expectations come
// from closed-form offsets after the accepting edge; data from a sector array model.
module tb_sd_sector_responder;

  localparam int WN     = 256;
  localparam int SN     = 4;
  localparam int INIT   = 100;
  localparam int CMD    = 8;
  localparam int GAP    = 4;
  localparam int PROG   = 16;
  localparam int REQ0   = 1 + CMD;                       // first wr_req offset
  localparam int WB_END = 1 + CMD + (WN - 1) * GAP + PROG; // last wr_busy offset
  localparam int RD0    = 2 + CMD;                       // first rd_data_en offset
  localparam int RB_END = RD0 + (WN - 1) * GAP;          // last rd_busy offset

  logic        sys_clk;
  logic        sys_rst;
  logic        init_end;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic        wr_req;
  logic [15:0] wr_data;
  logic        wr_busy;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic        rd_data_en;
  logic [15:0] rd_data;
  logic        rd_busy;

  int tests = 0;
  int fails = 0;

  logic [15:0] model   [SN][WN];
  bit          written [SN][WN];
  logic [15:0] src     [WN];

  sd_sector_responder dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .init_end   (init_end),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .wr_busy    (wr_busy),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data_en (rd_data_en),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Apply reset for one edge, check cleared outputs, then follow the init window.
  task automatic do_reset_init(input bit hold_wr);
    int bad = 0;
    wr_en   = hold_wr;
    rd_en   = 1'b0;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("rst init_end", init_end, 0);
    check("rst wr_req", wr_req, 0);
    check("rst wr_busy", wr_busy, 0);
    check("rst rd_data_en", rd_data_en, 0);
    check("rst rd_data", rd_data, 0);
    check("rst rd_busy", rd_busy, 0);
    sys_rst = 1'b0;
    for (int k = 1; k <= INIT; k++) begin
      @(negedge sys_clk);
      if (init_end !== 1'(k >= INIT)) bad++;
      if (wr_busy !== 1'b0 || rd_busy !== 1'b0) bad++;
      if (k == INIT - 1) check("init_end low before 100", init_end, 0);
    end
    check("init_end high at 100", init_end, 1);
    check("init window", bad, 0);
  endtask

  // Issue a write at the next edge and feed src[] on demand.
  task automatic do_write(input logic [31:0] addr, input bit with_rd);
    int  slot     = int'(addr % SN);
    int  k        = 0;
    int  n_req    = 0;
    int  bad_busy = 0;
    int  bad_req  = 0;
    int  bad_rd   = 0;
    bit  pend     = 1'b0;
    bit  exp_req;
    wr_addr = addr;
    wr_en   = 1'b1;
    if (with_rd) begin
      rd_en   = 1'b1;
      rd_addr = addr ^ 32'h1;
    end
    for (int o = 1; o <= WB_END + 4; o++) begin
      @(negedge sys_clk);
      if (o == 1) begin
        wr_en = 1'b0;
        rd_en = 1'b0;
      end
      if (with_rd && o == 500) rd_en = 1'b1;
      if (with_rd && o == 501) rd_en = 1'b0;
      exp_req = (o >= REQ0) && ((o - REQ0) % GAP == 0) && ((o - REQ0) / GAP < WN);
      if (wr_busy !== 1'(o <= WB_END)) bad_busy++;
      if (wr_req !== exp_req) bad_req++;
      if (rd_busy !== 1'b0 || rd_data_en !== 1'b0) bad_rd++;
      if (pend && k < WN) begin
        wr_data               = src[k];
        model[slot][k]        = src[k];
        written[slot][k]      = 1'b1;
        k++;
      end else begin
        wr_data = 16'($urandom);
      end
      if (wr_req === 1'b1) n_req++;
      pend = (wr_req === 1'b1);
    end
    check("wr_busy window", bad_busy, 0);
    check("wr_req timing", bad_req, 0);
    check("wr_req count", n_req, WN);
    check("read side quiet during write", bad_rd, 0);
  endtask

  // Issue a read at the next edge; abort_at > 0 returns after that many strobes.
  task automatic do_read(input logic [31:0] addr, input int abort_at);
    int          slot     = int'(addr % SN);
    int          idx      = 0;
    int          bad_busy = 0;
    int          bad_en   = 0;
    int          bad_data = 0;
    int          bad_hold = 0;
    int          bad_wr   = 0;
    bit          have_last = 1'b0;
    logic [15:0] last_exp = '0;
    bit          exp_en;
    rd_addr = addr;
    rd_en   = 1'b1;
    for (int o = 1; o <= RB_END + 4; o++) begin
      @(negedge sys_clk);
      if (o == 1) rd_en = 1'b0;
      exp_en = (o >= RD0) && ((o - RD0) % GAP == 0) && ((o - RD0) / GAP < WN);
      if (rd_busy !== 1'(o <= RB_END)) bad_busy++;
      if (rd_data_en !== exp_en) bad_en++;
      if (wr_busy !== 1'b0 || wr_req !== 1'b0) bad_wr++;
      if (rd_data_en === 1'b1) begin
        if (idx < WN) begin
          if (written[slot][idx] && rd_data !== model[slot][idx]) bad_data++;
          last_exp  = model[slot][idx];
          have_last = written[slot][idx];
          idx++;
        end
      end else if (have_last && rd_data !== last_exp) begin
        bad_hold++;
      end
      if (abort_at > 0 && idx == abort_at) break;
    end
    check("rd_busy window", bad_busy, 0);
    check("rd_data_en timing", bad_en, 0);
    check("rd_data words", bad_data, 0);
    check("rd_data hold", bad_hold, 0);
    check("write side quiet during read", bad_wr, 0);
    check("rd word count", idx, (abort_at > 0) ? abort_at : WN);
  endtask

  initial begin
    logic [31:0] a;
    sys_rst = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = '0;
    rd_addr = '0;
    wr_data = '0;

    // Init with wr_en held, then the held request becomes a ramp write to 1000.
    for (int i = 0; i < WN; i++) src[i] = 16'(i);
    do_reset_init(1'b1);
    do_write(32'd1000, 1'b0);
    do_read(32'd1000, 0);

    // Fill neighbouring slot and confirm slot 0 is untouched.
    for (int i = 0; i < WN; i++) src[i] = 16'hA5A5;
    do_write(32'd1001, 1'b0);
    do_read(32'd1000, 0);
    do_read(32'd1001, 0);

    // Simultaneous wr_en/rd_en plus a stray rd_en pulse while busy.
    for (int i = 0; i < WN; i++) src[i] = 16'($urandom);
    a = ($urandom & 32'hFFFF_FFFC) | 32'd2;
    do_write(a, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      check("no late read after collision", rd_busy, 0);
    end
    do_read(a, 0);

    // Random sectors with random upper address bits.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < WN; i++) src[i] = 16'($urandom);
      a = $urandom;
      do_write(a, 1'b0);
      do_read(a ^ 32'hFFFF_0000, 0);
    end

    // Reset in the middle of a read; contents must survive.
    do_read(32'd1000, 100);
    do_reset_init(1'b0);
    do_read(32'd1000, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
